aes_key_mem_mc: RTL

Multi-context AES round-key memory and word-serial key expander for AES-128, AES-192 and AES-256. It holds expanded schedules for `NUM_SLOTS` independent keys, so the cipher datapath can switch keys per block without re-expanding. It sits beside the encipher/decipher round datapath, shares one external 32-bit S-box word lookup, and serves a combinational 128-bit round-key read port.

---
 rtl/aes_key_pkg.sv | 41 ++++
 rtl/aes_key_mem_mc_store.sv | 41 ++++
 rtl/aes_key_mem_mc.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/aes_key_pkg.sv
// Shared constants, key-length decode helpers and FSM states for the multi-context AES key memory.
package aes_key_pkg;

    localparam logic [1:0] KEYLEN_128  = 2'b00;
    localparam logic [1:0] KEYLEN_256  = 2'b01;
    localparam logic [1:0] KEYLEN_192  = 2'b10;
    localparam logic [1:0] KEYLEN_RSVD = 2'b11;

    localparam int unsigned MAX_WORDS = 60;

    typedef enum logic [1:0] {StIdle, StLoad, StExpand, StDone} state_e;

    function automatic logic [5:0] nk_of(input logic [1:0] kl);
        case (kl)
            KEYLEN_256: return 6'd8;
            KEYLEN_192: return 6'd6;
            default:    return 6'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KEYLEN_256: return 4'd14;
            KEYLEN_192: return 4'd12;
            default:    return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input logic [1:0] kl);
        case (kl)
            KEYLEN_256: return 6'd60;
            KEYLEN_192: return 6'd52;
            default:    return 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_mem_mc_store.sv
// Slot x word round-key RAM: one word write port, a 4-word round read and a 1-word lookback read.
module aes_key_store
    import aes_key_pkg::*;
#(
    parameter int unsigned NumSlots = 4,
    parameter int unsigned SlotW    = 2
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [SlotW-1:0]  wr_slot_i,
    input  logic [5:0]        wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [SlotW-1:0]  rd_slot_i,
    input  logic [3:0]        rd_round_i,
    output logic [127:0]      rd_data_o,
    input  logic [SlotW-1:0]  aux_slot_i,
    input  logic [5:0]        aux_addr_i,
    output logic [31:0]       aux_data_o
);

    logic [31:0] mem_q [NumSlots][MAX_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i && (wr_addr_i < 6'(MAX_WORDS))) begin
            mem_q[wr_slot_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Rounds past the end of storage read as zero rather than indexing off the array.
    always_comb begin
        rd_data_o = '0;
        for (int j = 0; j < 4; j++) begin
            if ({rd_round_i, 2'(j)} < 6'(MAX_WORDS)) begin
                rd_data_o[127-32*j -: 32] = mem_q[rd_slot_i][{rd_round_i, 2'(j)}];
            end
        end
    end

    assign aux_data_o = (aux_addr_i < 6'(MAX_WORDS)) ? mem_q[aux_slot_i][aux_addr_i] : 32'h0;

endmodule

// File: rtl/aes_key_mem_mc.sv
// Multi-context AES-128/192/256 round-key store with a word-serial expander sharing one S-box.
module aes_key_mem_mc
    import aes_key_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [255:0]         key,
    input  logic [1:0]           keylen,
    input  logic                 init,
    input  logic [SLOT_W-1:0]    init_slot,
    output logic                 ready,
    output logic                 error,
    output logic [NUM_SLOTS-1:0] slot_valid,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic [3:0]           rd_round,
    output logic [127:0]         round_key,
    output logic                 rd_valid,
    output logic [31:0]          sboxw,
    input  logic [31:0]          new_sboxw
);

    state_e                state_q;
    logic [1:0]            keylen_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [5:0]            i_q;
    logic [2:0]            p_q;
    logic [7:0]            rcon_q;
    logic [31:0]           prev_w_q;
    logic [NUM_SLOTS-1:0]  slot_valid_q;
    logic                  error_q;
    logic [1:0]            slot_kl_q [NUM_SLOTS];

    logic [5:0]  nk, nw;
    logic [2:0]  p_next;
    logic [31:0] key_word, f_word, exp_word, wr_data;
    logic        we;

    assign nk = nk_of(keylen_q);
    assign nw = nw_of(keylen_q);
    assign p_next = ({3'b0, p_q} == nk - 6'd1) ? 3'd0 : p_q + 3'd1;

    // Word i of the MSB-aligned key starts at bit 255 - 32*i, i.e. {~i, 5'b11111}.
    assign key_word = key[{~i_q[2:0], 5'b11111} -: 32];

    always_comb begin
        exp_word = f_word ^ prev_w_q;
        if (p_q == 3'd0) begin
            exp_word = f_word ^ {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0};
        end else if ((keylen_q == KEYLEN_256) && (p_q == 3'd4)) begin
            exp_word = f_word ^ new_sboxw;
        end
    end

    assign we      = (state_q == StLoad) || ((state_q == StExpand) && (i_q < nw));
    assign wr_data = (state_q == StLoad) ? key_word : exp_word;

    aes_key_store #(
        .NumSlots (NUM_SLOTS),
        .SlotW    (SLOT_W)
    ) u_store (
        .clk_i      (clk),
        .we_i       (we),
        .wr_slot_i  (slot_q),
        .wr_addr_i  (i_q),
        .wr_data_i  (wr_data),
        .rd_slot_i  (rd_slot),
        .rd_round_i (rd_round),
        .rd_data_o  (round_key),
        .aux_slot_i (slot_q),
        .aux_addr_i (i_q - nk),
        .aux_data_o (f_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            keylen_q     <= KEYLEN_128;
            slot_q       <= '0;
            i_q          <= '0;
            p_q          <= '0;
            rcon_q       <= 8'h01;
            prev_w_q     <= '0;
            slot_valid_q <= '0;
            error_q      <= 1'b0;
            slot_kl_q    <= '{default: KEYLEN_128};
        end else begin
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (init) begin
                        if (keylen == KEYLEN_RSVD) begin
                            error_q <= 1'b1;
                        end else begin
                            keylen_q                <= keylen;
                            slot_q                  <= init_slot;
                            slot_kl_q[init_slot]    <= keylen;
                            slot_valid_q[init_slot] <= 1'b0;
                            i_q                     <= '0;
                            p_q                     <= '0;
                            rcon_q                  <= 8'h01;
                            state_q                 <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    prev_w_q <= wr_data;
                    i_q      <= i_q + 6'd1;
                    p_q      <= p_next;
                    if (i_q == nk - 6'd1) begin
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    if (i_q == nw) begin
                        state_q <= StDone;
                    end else begin
                        prev_w_q <= wr_data;
                        i_q      <= i_q + 6'd1;
                        p_q      <= p_next;
                        if (p_q == 3'd0) begin
                            rcon_q <= xtime(rcon_q);
                        end
                    end
                end
                StDone: begin
                    slot_valid_q[slot_q] <= 1'b1;
                    state_q              <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready      = (state_q == StIdle);
    assign error      = error_q;
    assign slot_valid = slot_valid_q;
    assign sboxw      = prev_w_q;
    assign rd_valid   = slot_valid_q[rd_slot] && (rd_round <= nr_of(slot_kl_q[rd_slot]));

endmodule
